// File: rtl/core_reg_wb_arb.sv
// ---------------------------------------------------------------------------
// core_reg_wb_arb
//   Three requesters share the single write port of the integer register
//   file: ALU writeback, load writeback and input byte. This block also drives
//   the page-register write port, which has its own independent sequencer.
//   The register file samples WE/INE one cycle late but uses WADDR/WDATA/INDATA
//   live. For that reason address and data are held for both the enable cycle
//   and the cycle after it.
//
//   Ports
//     CLK, RST_N               clock, asynchronous active-low reset
//     ALU_VALID/RD/DATA/READY  ALU writeback request, accepted when READY=1
//     LD_VALID/RD/DATA/READY   load writeback request
//     IN_VALID/RD/BYTE/READY   input-byte request (low 8 bits only)
//     PG_VALID/ADDR/DATA/READY page-register write request
//     WE, INE                  register-file word / byte write enables
//     WADDR, WDATA, INDATA     register-file write address and data
//     PWE, PWADDR, PWDATA      page-register write port
//     PENDING                  bit r set while a write to register r is in flight
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no write in flight, grant allowed
//   ISSUE  | enable high, address/data stable
//   HOLD   | enable low, address/data still stable, commit at end; grant allowed
//   PIDLE  | page port idle, grant allowed
//   PISSUE | PWE high, page address/data stable
//   PHOLD  | PWE low, page address/data stable; grant allowed
// ---------------------------------------------------------------------------
module core_reg_wb_arb #(
    parameter int XLEN  = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            ALU_VALID,
    input  logic [4:0]      ALU_RD,
    input  logic [XLEN-1:0] ALU_DATA,
    output logic            ALU_READY,
    input  logic            LD_VALID,
    input  logic [4:0]      LD_RD,
    input  logic [XLEN-1:0] LD_DATA,
    output logic            LD_READY,
    input  logic            IN_VALID,
    input  logic [4:0]      IN_RD,
    input  logic [7:0]      IN_BYTE,
    output logic            IN_READY,
    input  logic            PG_VALID,
    input  logic [4:0]      PG_ADDR,
    input  logic [XLEN-1:0] PG_DATA,
    output logic            PG_READY,
    output logic            WE,
    output logic            INE,
    output logic [4:0]      WADDR,
    output logic [XLEN-1:0] WDATA,
    output logic [7:0]      INDATA,
    output logic            PWE,
    output logic [4:0]      PWADDR,
    output logic [XLEN-1:0] PWDATA,
    output logic [31:0]     PENDING
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2} reg_state_t;
    typedef enum logic [1:0] {PIDLE = 2'd0, PISSUE = 2'd1, PHOLD = 2'd2} pg_state_t;

    reg_state_t      reg_state;
    pg_state_t       pg_state;
    logic [1:0]      rr_ptr;      // requester with highest priority next: 0 ALU, 1 LD, 2 IN
    logic [1:0]      ptr_next;
    logic [2:0]      req;
    logic [5:0]      req_dup;
    logic [2:0]      rot;
    logic [2:0]      pick;
    logic [5:0]      gnt_wide;
    logic [2:0]      gnt;
    logic            reg_open;
    logic            pg_open;
    logic            any_gnt;
    logic            wr_gnt;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     pend_set;
    logic [31:0]     pend_clr;

    assign req      = {IN_VALID, LD_VALID, ALU_VALID};
    assign reg_open = RST_N && ((reg_state == IDLE) || (reg_state == HOLD));
    assign pg_open  = RST_N && ((pg_state == PIDLE) || (pg_state == PHOLD));

    // Round robin: rotate the request vector so the priority holder sits at
    // bit 0, then pick the lowest set bit and rotate the grant back.
    always_comb begin
        req_dup  = {req, req} >> rr_ptr;
        rot      = req_dup[2:0];
        pick     = '0;
        gnt_wide = '0;
        if (RR_EN) begin
            pick     = rot & (~rot + 3'd1);
            gnt_wide = {3'b000, pick} << rr_ptr;
            gnt      = gnt_wide[2:0] | gnt_wide[5:3];
        end else begin
            gnt = req & (~req + 3'd1);
        end
        if (!reg_open) begin
            gnt = '0;
        end
    end

    always_comb begin
        sel_rd   = ALU_RD;
        sel_data = ALU_DATA;
        if (gnt[1]) begin
            sel_rd   = LD_RD;
            sel_data = LD_DATA;
        end else if (gnt[2]) begin
            sel_rd = IN_RD;
        end
    end

    always_comb begin
        ptr_next = 2'd0;
        if (gnt[0]) begin
            ptr_next = 2'd1;
        end else if (gnt[1]) begin
            ptr_next = 2'd2;
        end
    end

    // A grant to r0 is acknowledged but produces no write at all.
    assign any_gnt  = |gnt;
    assign wr_gnt   = any_gnt && (sel_rd != 5'd0);
    assign pend_set = wr_gnt ? (32'd1 << sel_rd) : 32'd0;
    assign pend_clr = (reg_state == HOLD) ? (32'd1 << WADDR) : 32'd0;

    assign ALU_READY = gnt[0];
    assign LD_READY  = gnt[1];
    assign IN_READY  = gnt[2];
    assign PG_READY  = PG_VALID && pg_open;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reg_state <= IDLE;
            rr_ptr    <= 2'd0;
            WE        <= 1'b0;
            INE       <= 1'b0;
            WADDR     <= '0;
            WDATA     <= '0;
            INDATA    <= '0;
            PENDING   <= '0;
        end else begin
            if (any_gnt) begin
                rr_ptr <= ptr_next;
            end
            // Set is applied after clear, so a new write to the register just
            // committing keeps its bit.
            PENDING <= ((PENDING & ~pend_clr) | pend_set) & 32'hFFFF_FFFE;
            case (reg_state)
                IDLE, HOLD: begin
                    WE  <= 1'b0;
                    INE <= 1'b0;
                    if (wr_gnt) begin
                        reg_state <= ISSUE;
                        WADDR     <= sel_rd;
                        if (gnt[2]) begin
                            INE    <= 1'b1;
                            INDATA <= IN_BYTE;
                        end else begin
                            WE    <= 1'b1;
                            WDATA <= sel_data;
                        end
                    end else begin
                        reg_state <= IDLE;
                    end
                end
                ISSUE: begin
                    WE        <= 1'b0;
                    INE       <= 1'b0;
                    reg_state <= HOLD;
                end
                default: begin
                    WE        <= 1'b0;
                    INE       <= 1'b0;
                    reg_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pg_state <= PIDLE;
            PWE      <= 1'b0;
            PWADDR   <= '0;
            PWDATA   <= '0;
        end else begin
            case (pg_state)
                PIDLE, PHOLD: begin
                    if (PG_READY) begin
                        pg_state <= PISSUE;
                        PWE      <= 1'b1;
                        PWADDR   <= PG_ADDR;
                        PWDATA   <= PG_DATA;
                    end else begin
                        pg_state <= PIDLE;
                        PWE      <= 1'b0;
                    end
                end
                PISSUE: begin
                    PWE      <= 1'b0;
                    pg_state <= PHOLD;
                end
                default: begin
                    PWE      <= 1'b0;
                    pg_state <= PIDLE;
                end
            endcase
        end
    end

endmodule
